io_bus_bridge: RTL and testbench



---
 rtl/io_bus_bridge_pkg.sv | 44 ++++
 rtl/io_bus_bridge_if.sv | 23 ++
 rtl/io_bus_bridge_seg7_decode.sv | 31 +++
 rtl/io_bus_bridge.sv | 122 ++++++++++++
 tb/tb_io_bus_bridge.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_bridge_pkg.sv
// Shared constants, address-select type and decode helper for the I/O bus bridge.
package io_bus_bridge_pkg;

   localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;
   localparam logic [31:0] OFF_TUBE  = 32'h0000_0000;
   localparam logic [31:0] OFF_TIMER = 32'h0000_0020;
   localparam logic [31:0] OFF_LED   = 32'h0000_0060;
   localparam logic [31:0] OFF_SW    = 32'h0000_0070;

   // All segments off (active-low), decimal point included.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [2:0] {
      SelDram,
      SelTube,
      SelTimer,
      SelLed,
      SelSw,
      SelNone
   } sel_e;

   // Classify a byte address; the low two bits only matter for the DRAM/IO split.
   function automatic sel_e addr_sel(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] word;
      word = {addr[31:2], 2'b00};
      if (addr < base) begin
         return SelDram;
      end
      if (word == base + OFF_TUBE) begin
         return SelTube;
      end
      if (word == base + OFF_TIMER) begin
         return SelTimer;
      end
      if (word == base + OFF_LED) begin
         return SelLed;
      end
      if (word == base + OFF_SW) begin
         return SelSw;
      end
      return SelNone;
   endfunction

endpackage

// File: rtl/io_bus_bridge_if.sv
// Core-side data-memory bus: request from the MEM stage, combinational load data back.
interface io_bus_bridge_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;

   modport master (
      output addr,
      output wdata,
      output we,
      input  rdata
   );

   modport slave (
      input  addr,
      input  wdata,
      input  we,
      output rdata
   );

endinterface

// File: rtl/io_bus_bridge_seg7_decode.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module io_bus_bridge_seg7_decode (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   // Pure lookup; all 16 codes are covered.
   always_comb begin
      seg_o = 7'h7F;
      case (hex_i)
         4'h0:    seg_o = 7'h40;
         4'h1:    seg_o = 7'h79;
         4'h2:    seg_o = 7'h24;
         4'h3:    seg_o = 7'h30;
         4'h4:    seg_o = 7'h19;
         4'h5:    seg_o = 7'h12;
         4'h6:    seg_o = 7'h02;
         4'h7:    seg_o = 7'h78;
         4'h8:    seg_o = 7'h00;
         4'h9:    seg_o = 7'h10;
         4'hA:    seg_o = 7'h08;
         4'hB:    seg_o = 7'h03;
         4'hC:    seg_o = 7'h46;
         4'hD:    seg_o = 7'h21;
         4'hE:    seg_o = 7'h06;
         4'hF:    seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/io_bus_bridge.sv
// Routes core data accesses to DRAM or to the LED/switch/tube/timer peripherals and
// drives the multiplexed 7-segment scan.
module io_bus_bridge #(
   parameter int unsigned DRAM_AW  = 14,
   parameter int unsigned SCAN_DIV = 50000,
   parameter logic [31:0] IO_BASE  = io_bus_bridge_pkg::IO_BASE
) (
   input  logic               clk,
   input  logic               rst_n,
   io_bus_bridge_if.slave     bus,
   output logic [DRAM_AW-1:0] dram_addr_o,
   output logic [31:0]        dram_wdata_o,
   output logic               dram_we_o,
   input  logic [31:0]        dram_rdata_i,
   input  logic [23:0]        sw_i,
   output logic [23:0]        led_o,
   output logic [7:0]         seg_en_o,
   output logic [7:0]         seg_o
);

   import io_bus_bridge_pkg::*;

   localparam int unsigned    CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

   sel_e sel;

   logic [23:0]     led_q, led_d;
   logic [31:0]     tube_q, tube_d;
   logic [31:0]     timer_q, timer_d;
   logic [23:0]     sync1_q, sync1_d;
   logic [23:0]     sync2_q, sync2_d;
   logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      seg_en_q, seg_en_d;
   logic [7:0]      seg_q, seg_d;
   logic [6:0]      digit_seg;

   assign sel = addr_sel(bus.addr, IO_BASE);

   // DRAM sees the request unconditionally; only the write strobe is gated.
   assign dram_addr_o  = bus.addr[DRAM_AW+1:2];
   assign dram_wdata_o = bus.wdata;
   assign dram_we_o    = bus.we && (sel == SelDram);

   assign led_o    = led_q;
   assign seg_en_o = seg_en_q;
   assign seg_o    = seg_q;

   io_bus_bridge_seg7_decode u_seg7_decode (
      .hex_i (tube_q[{idx_q, 2'b00} +: 4]),
      .seg_o (digit_seg)
   );

   // Load data mux; unmapped peripheral addresses read as zero.
   always_comb begin
      bus.rdata = '0;
      case (sel)
         SelDram:  bus.rdata = dram_rdata_i;
         SelTube:  bus.rdata = tube_q;
         SelTimer: bus.rdata = timer_q;
         SelLed:   bus.rdata = {8'h00, led_q};
         SelSw:    bus.rdata = {8'h00, sync2_q};
         default:  bus.rdata = '0;
      endcase
   end

   // Peripheral register updates; a timer store overrides that cycle's increment.
   always_comb begin
      led_d   = led_q;
      tube_d  = tube_q;
      timer_d = timer_q + 32'd1;
      sync1_d = sw_i;
      sync2_d = sync1_q;
      if (bus.we) begin
         case (sel)
            SelTube:  tube_d  = bus.wdata;
            SelTimer: timer_d = bus.wdata;
            SelLed:   led_d   = bus.wdata[23:0];
            default:  ;
         endcase
      end
   end

   // Scan timing and registered digit outputs, which trail idx by one cycle.
   always_comb begin
      scan_cnt_d = scan_cnt_q + CntW'(1);
      idx_d      = idx_q;
      if (scan_cnt_q == CntMax) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 3'd1;
      end
      seg_en_d = ~(8'b0000_0001 << idx_q);
      seg_d    = {1'b1, digit_seg};
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q      <= '0;
         tube_q     <= '0;
         timer_q    <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_en_q   <= SEG_BLANK;
         seg_q      <= SEG_BLANK;
      end else begin
         led_q      <= led_d;
         tube_q     <= tube_d;
         timer_q    <= timer_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_en_q   <= seg_en_d;
         seg_q      <= seg_d;
      end
   end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge with a cycle-level behavioural model.
module tb_io_bus_bridge;

   localparam int unsigned DRAM_AW  = 14;
   localparam int unsigned SCAN_DIV = 4;
   localparam logic [31:0] IOB     = 32'hFFFF_F000;
   localparam logic [31:0] A_TUBE  = 32'hFFFF_F000;
   localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
   localparam logic [31:0] A_LED   = 32'hFFFF_F060;
   localparam logic [31:0] A_SW    = 32'hFFFF_F070;
   localparam logic [31:0] A_UNM   = 32'hFFFF_F040;
   localparam logic [31:0] A_DRAM0 = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   io_bus_bridge_if bus_if ();

   logic [DRAM_AW-1:0] dram_addr;
   logic [31:0]        dram_wdata;
   logic               dram_we;
   logic [31:0]        dram_rdata;
   logic [23:0]        sw = 24'h0;
   logic [23:0]        led;
   logic [7:0]         seg_en;
   logic [7:0]         seg;

   io_bus_bridge #(
      .DRAM_AW  (DRAM_AW),
      .SCAN_DIV (SCAN_DIV),
      .IO_BASE  (IOB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus_if),
      .dram_addr_o  (dram_addr),
      .dram_wdata_o (dram_wdata),
      .dram_we_o    (dram_we),
      .dram_rdata_i (dram_rdata),
      .sw_i         (sw),
      .led_o        (led),
      .seg_en_o     (seg_en),
      .seg_o        (seg)
   );

   // Simple combinational-read DRAM driven by the DUT.
   logic [31:0] mem [0:(1<<DRAM_AW)-1];
   assign dram_rdata = mem[dram_addr];
   always @(posedge clk) if (dram_we) mem[dram_addr] <= dram_wdata;

   // Reference model state.
   logic [23:0] led_m;
   logic [31:0] tube_m;
   logic [31:0] timer_m;
   logic [23:0] s1_m, s2_m;
   logic [7:0]  seg_en_m, seg_m;
   logic [31:0] dram_m [0:15];
   int          cyc;

   int nchk = 0;
   int npass = 0;

   function automatic logic [7:0] hex_seg(input logic [3:0] h);
      case (h)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (a < IOB) return dram_m[a[5:2]];
      case (w)
         A_TUBE:  return tube_m;
         A_TIMER: return timer_m;
         A_LED:   return {8'h00, led_m};
         A_SW:    return {8'h00, s2_m};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      led_m = '0; tube_m = '0; timer_m = '0; s1_m = '0; s2_m = '0;
      seg_en_m = 8'hFF; seg_m = 8'hFF; cyc = 0;
   endtask

   task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic w);
      bus_if.addr = a; bus_if.wdata = d; bus_if.we = w;
   endtask

   // One clock: predict the edge from current inputs, wait for it, return at negedge.
   task automatic tick();
      int          idx;
      logic [7:0]  n_seg_en, n_seg;
      logic [31:0] n_timer, a, d;
      logic [23:0] n_s1, n_s2;
      idx      = (cyc / SCAN_DIV) % 8;
      n_seg_en = ~(8'h01 << idx);
      n_seg    = hex_seg(4'((tube_m >> (4 * idx)) & 32'hF));
      n_timer  = timer_m + 32'd1;
      n_s1     = sw;
      n_s2     = s1_m;
      a = bus_if.addr; d = bus_if.wdata;
      if (bus_if.we) begin
         if (a < IOB) dram_m[a[5:2]] = d;
         else if ({a[31:2], 2'b00} == A_TUBE) tube_m = d;
         else if ({a[31:2], 2'b00} == A_TIMER) n_timer = d;
         else if ({a[31:2], 2'b00} == A_LED) led_m = d[23:0];
      end
      @(posedge clk);
      timer_m = n_timer; s1_m = n_s1; s2_m = n_s2;
      seg_en_m = n_seg_en; seg_m = n_seg; cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      sw = 24'hABCDEF;
      set_bus(A_SW, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      nchk++; if (led !== 24'h0) $display("FAIL reset_led got %h want %h", led, 24'h0); else npass++;
      nchk++; if (seg_en !== 8'hFF) $display("FAIL reset_seg_en got %h want FF", seg_en); else npass++;
      nchk++; if (seg !== 8'hFF) $display("FAIL reset_seg got %h want FF", seg); else npass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      nchk++; if (bus_if.rdata !== 32'h0) $display("FAIL sw_sync1 got %h want 0", bus_if.rdata); else npass++;
      nchk++; if (seg_en !== 8'hFE) $display("FAIL first_digit got %h want FE", seg_en); else npass++;
      tick();
      nchk++; if (bus_if.rdata !== 32'h00AB_CDEF) $display("FAIL sw_sync2 got %h want 00ABCDEF", bus_if.rdata); else npass++;
   endtask

   task automatic test_dram();
      logic [31:0] a, d;
      for (int i = 0; i < 16; i++) begin
         a = A_DRAM0 + 32'(4 * i);
         d = (i == 1) ? 32'h1234_5678 : $urandom;
         set_bus(a, d, 1'b1);
         #1;
         nchk++; if (dram_we !== 1'b1) $display("FAIL dram_we_%0d got %b want 1", i, dram_we); else npass++;
         nchk++; if (dram_addr !== a[DRAM_AW+1:2]) $display("FAIL dram_addr_%0d got %h want %h", i, dram_addr, a[DRAM_AW+1:2]); else npass++;
         nchk++; if (dram_wdata !== d) $display("FAIL dram_wdata_%0d got %h want %h", i, dram_wdata, d); else npass++;
         tick();
      end
      set_bus(32'h0000_0104, 32'h0, 1'b0);
      #1;
      nchk++; if (dram_addr !== 14'h41) $display("FAIL dram_addr_104 got %h want 41", dram_addr); else npass++;
      nchk++; if (bus_if.rdata !== 32'h1234_5678) $display("FAIL dram_load_104 got %h want 12345678", bus_if.rdata); else npass++;
      for (int i = 0; i < 16; i++) begin
         a = A_DRAM0 + 32'(4 * i);
         set_bus(a, 32'h0, 1'b0);
         #1;
         nchk++; if (bus_if.rdata !== exp_rd(a)) $display("FAIL dram_load_%0d got %h want %h", i, bus_if.rdata, exp_rd(a)); else npass++;
      end
      set_bus(A_LED, 32'h0, 1'b1);
      #1;
      nchk++; if (dram_we !== 1'b0) $display("FAIL dram_we_io got %b want 0", dram_we); else npass++;
      set_bus(A_LED, 32'h0, 1'b0);
   endtask

   task automatic test_led();
      set_bus(A_LED, 32'hFF12_3456, 1'b1);
      tick();
      set_bus(A_LED, 32'h0, 1'b0);
      #1;
      nchk++; if (led !== 24'h12_3456) $display("FAIL led_out got %h want 123456", led); else npass++;
      nchk++; if (bus_if.rdata !== 32'h0012_3456) $display("FAIL led_read got %h want 00123456", bus_if.rdata); else npass++;
      set_bus(A_UNM, 32'hDEAD_BEEF, 1'b1);
      #1;
      nchk++; if (bus_if.rdata !== 32'h0) $display("FAIL unmapped_read got %h want 0", bus_if.rdata); else npass++;
      tick();
      set_bus(A_SW, 32'hFFFF_FFFF, 1'b1);
      tick();
      set_bus(A_SW, 32'h0, 1'b0);
      #1;
      nchk++; if (led !== 24'h12_3456) $display("FAIL led_after_unmapped got %h want 123456", led); else npass++;
      nchk++; if (bus_if.rdata !== exp_rd(A_SW)) $display("FAIL sw_write_ignored got %h want %h", bus_if.rdata, exp_rd(A_SW)); else npass++;
   endtask

   task automatic test_timer();
      set_bus(A_TIMER, 32'hFFFF_FFFE, 1'b1);
      tick();
      set_bus(A_TIMER, 32'h0, 1'b0);
      #1;
      nchk++; if (bus_if.rdata !== 32'hFFFF_FFFE) $display("FAIL timer_load got %h want FFFFFFFE", bus_if.rdata); else npass++;
      tick();
      nchk++; if (bus_if.rdata !== 32'hFFFF_FFFF) $display("FAIL timer_inc got %h want FFFFFFFF", bus_if.rdata); else npass++;
      tick();
      nchk++; if (bus_if.rdata !== 32'h0) $display("FAIL timer_wrap got %h want 0", bus_if.rdata); else npass++;
      tick();
      nchk++; if (bus_if.rdata !== exp_rd(A_TIMER)) $display("FAIL timer_resume got %h want %h", bus_if.rdata, exp_rd(A_TIMER)); else npass++;
   endtask

   task automatic test_scan();
      rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      set_bus(A_TUBE, 32'h8765_4321, 1'b1);
      tick();
      set_bus(A_TUBE, 32'h0, 1'b0);
      nchk++; if (seg !== 8'hC0) $display("FAIL scan_first got %h want C0", seg); else npass++;
      for (int k = 2; k <= 34; k++) begin
         tick();
         nchk++; if (seg_en !== seg_en_m) $display("FAIL scan_en_%0d got %h want %h", k, seg_en, seg_en_m); else npass++;
         nchk++; if (seg !== seg_m) $display("FAIL scan_seg_%0d got %h want %h", k, seg, seg_m); else npass++;
         if (k == 2 || k == 33) begin
            nchk++; if ({seg_en, seg} !== 16'hFEF9) $display("FAIL scan_digit0_%0d got %h want FEF9", k, {seg_en, seg}); else npass++;
         end
         if (k == 4) begin
            nchk++; if (seg_en !== 8'hFE) $display("FAIL scan_hold got %h want FE", seg_en); else npass++;
         end
         if (k == 5) begin
            nchk++; if ({seg_en, seg} !== 16'hFDA4) $display("FAIL scan_digit1 got %h want FDA4", {seg_en, seg}); else npass++;
         end
         if (k == 32) begin
            nchk++; if ({seg_en, seg} !== 16'h7F80) $display("FAIL scan_digit7 got %h want 7F80", {seg_en, seg}); else npass++;
         end
      end
   endtask

   task automatic test_mid_reset();
      int guard;
      guard = 0;
      while (seg_en_m !== 8'hDF && guard < 64) begin
         tick();
         guard++;
      end
      nchk++; if (seg_en !== 8'hDF) $display("FAIL midrst_idx5 got %h want DF", seg_en); else npass++;
      set_bus(A_TUBE, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      nchk++; if (seg_en !== 8'hFF) $display("FAIL midrst_seg_en got %h want FF", seg_en); else npass++;
      nchk++; if (seg !== 8'hFF) $display("FAIL midrst_seg got %h want FF", seg); else npass++;
      nchk++; if (bus_if.rdata !== 32'h0) $display("FAIL midrst_tube got %h want 0", bus_if.rdata); else npass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      nchk++; if ({seg_en, seg} !== 16'hFEC0) $display("FAIL midrst_restart got %h want FEC0", {seg_en, seg}); else npass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         set_bus(A_LED, v, 1'b1);
         tick();
         nchk++; if (led !== v[23:0]) $display("FAIL b2b_led_%0d got %h want %h", i, led, v[23:0]); else npass++;
      end
      set_bus(A_LED, 32'h0, 1'b0);
      #1;
      nchk++; if (bus_if.rdata !== {8'h00, v[23:0]}) $display("FAIL b2b_led_last got %h want %h", bus_if.rdata, {8'h00, v[23:0]}); else npass++;
      for (int i = 0; i < 3; i++) begin
         v = $urandom;
         set_bus(A_TIMER, v, 1'b1);
         tick();
      end
      set_bus(A_TIMER, 32'h0, 1'b0);
      #1;
      nchk++; if (bus_if.rdata !== v) $display("FAIL b2b_timer_last got %h want %h", bus_if.rdata, v); else npass++;
   endtask

   task automatic test_random();
      logic [31:0] unm [7];
      logic [31:0] a, d;
      logic        w;
      unm = '{32'hFFFF_F004, 32'hFFFF_F010, 32'hFFFF_F024, 32'hFFFF_F064,
              32'hFFFF_F074, 32'hFFFF_FFFC, 32'hFFFF_F100};
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0:       a = A_DRAM0 + 32'(4 * $urandom_range(0, 15));
            1:       a = A_TUBE;
            2:       a = A_TIMER;
            3:       a = A_LED;
            4:       a = A_SW;
            default: a = unm[$urandom_range(0, 6)];
         endcase
         a[1:0] = 2'($urandom_range(0, 3));
         d = $urandom;
         w = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
         set_bus(a, d, w);
         #1;
         nchk++; if (bus_if.rdata !== exp_rd(a)) $display("FAIL rnd_rdata_%0d addr %h got %h want %h", n, a, bus_if.rdata, exp_rd(a)); else npass++;
         nchk++; if (dram_we !== (w && (a < IOB))) $display("FAIL rnd_dram_we_%0d got %b want %b", n, dram_we, w && (a < IOB)); else npass++;
         nchk++; if (led !== led_m) $display("FAIL rnd_led_%0d got %h want %h", n, led, led_m); else npass++;
         nchk++; if ({seg_en, seg} !== {seg_en_m, seg_m}) $display("FAIL rnd_scan_%0d got %h want %h", n, {seg_en, seg}, {seg_en_m, seg_m}); else npass++;
         tick();
      end
      set_bus(A_LED, 32'h0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) dram_m[i] = 32'h0;
      set_bus(32'h0, 32'h0, 1'b0);
      model_reset();
      test_reset();
      test_dram();
      test_led();
      test_timer();
      test_scan();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
